// File: rtl/layer_mac_sequencer.sv
// Serial binary-weight fully-connected layer: one multiply-accumulate per cycle,
// walking the output neurons in order and writing saturated results to the next buffer.
module layer_mac_sequencer #(
  parameter int dataWidth     = 8,
  parameter int NsInPrevLayer = 784,
  parameter int NsInNextLayer = 30,
  parameter int accWidth      = dataWidth + $clog2(NsInPrevLayer) + 1,
  localparam int AW = (NsInPrevLayer > 1) ? $clog2(NsInPrevLayer) : 1,
  localparam int MW = (NsInNextLayer > 1) ? $clog2(NsInNextLayer) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     wt_rd_en,
  output logic [MW-1:0]            wt_row_addr,
  input  logic [NsInPrevLayer-1:0] wt_row,
  output logic                     act_rd_en,
  output logic [AW-1:0]            act_addr,
  input  logic [dataWidth-1:0]     act_data,
  output logic                     out_we,
  output logic [MW-1:0]            out_addr,
  output logic [dataWidth-1:0]     out_data
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, WRITE, DONE} state_t;

  localparam logic [AW-1:0] LAST_J = AW'(NsInPrevLayer - 1);
  localparam logic [MW-1:0] LAST_I = MW'(NsInNextLayer - 1);

  state_t                   state_q, state_d;
  logic [MW-1:0]            i_q, i_d;
  logic [AW-1:0]            j_q, j_d;
  logic [accWidth-1:0]      acc_q, acc_d;
  logic [NsInPrevLayer-1:0] rowreg_q, rowreg_d;
  logic [accWidth-1:0]      act_ext;
  logic                     sat;

  assign act_ext = accWidth'(act_data);
  assign sat     = |acc_q[accWidth-1:dataWidth];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      rowreg_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      rowreg_q <= rowreg_d;
    end
  end

  // Read data arrives one cycle after its strobe, so MAC cycle j consumes element j-1
  // and DRAIN consumes the last one.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    rowreg_d    = rowreg_q;
    busy        = 1'b0;
    done        = 1'b0;
    wt_rd_en    = 1'b0;
    wt_row_addr = '0;
    act_rd_en   = 1'b0;
    act_addr    = '0;
    out_we      = 1'b0;
    out_addr    = '0;
    out_data    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          i_d     = '0;
        end
      end
      LOAD: begin
        busy        = 1'b1;
        wt_rd_en    = 1'b1;
        wt_row_addr = i_q;
        j_d         = '0;
        state_d     = MAC;
      end
      MAC: begin
        busy      = 1'b1;
        act_rd_en = 1'b1;
        act_addr  = j_q;
        if (j_q == '0) begin
          rowreg_d = wt_row;
        end else if (rowreg_q[j_q - 1'b1]) begin
          acc_d = acc_q + act_ext;
        end
        if (j_q == LAST_J) begin
          state_d = DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (rowreg_q[NsInPrevLayer-1]) begin
          acc_d = acc_q + act_ext;
        end
        state_d = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        out_we   = 1'b1;
        out_addr = i_q;
        out_data = sat ? '1 : acc_q[dataWidth-1:0];
        acc_d    = '0;
        if (i_q == LAST_I) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Self-checking bench for layer_mac_sequencer: directed and random layers compared
// cycle by cycle against a sum-and-clamp reference and the layer timing rules.
module tb_layer_mac_sequencer;
  localparam int DW       = 8;
  localparam int N        = 4;
  localparam int M        = 3;
  localparam int PER      = N + 3;
  localparam int DONE_CYC = M * PER + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, wt_rd_en, act_rd_en, out_we;
  logic [1:0]    wt_row_addr, out_addr;
  logic [1:0]    act_addr;
  logic [N-1:0]  wt_row;
  logic [DW-1:0] act_data, out_data;

  logic [N-1:0]  rows [M];
  logic [DW-1:0] acts [N];

  int tests_run    = 0;
  int tests_failed = 0;

  layer_mac_sequencer #(
    .dataWidth(DW),
    .NsInPrevLayer(N),
    .NsInNextLayer(M)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .wt_rd_en(wt_rd_en),
    .wt_row_addr(wt_row_addr),
    .wt_row(wt_row),
    .act_rd_en(act_rd_en),
    .act_addr(act_addr),
    .act_data(act_data),
    .out_we(out_we),
    .out_addr(out_addr),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Synchronous buffers; junk on the bus whenever a read was not requested.
  always @(posedge clk) begin
    wt_row   <= wt_rd_en ? rows[wt_row_addr] : N'($urandom);
    act_data <= act_rd_en ? acts[act_addr] : DW'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  function automatic int ref_out(input int i);
    int sum = 0;
    for (int j = 0; j < N; j++) if (rows[i][j]) sum += int'(acts[j]);
    return (sum > 255) ? 255 : sum;
  endfunction

  task automatic check_idle(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " wt_rd_en"}, 32'(wt_rd_en), 0);
    checkOutput({tag, " act_rd_en"}, 32'(act_rd_en), 0);
    checkOutput({tag, " out_we"}, 32'(out_we), 0);
    checkOutput({tag, " addrs"}, 32'({wt_row_addr, act_addr, out_addr}), 0);
    checkOutput({tag, " out_data"}, 32'(out_data), 0);
  endtask

  // Entered at a falling edge with the DUT idle: that cycle is cycle 0 of the layer.
  // Extra start pulses go at cycles p0..p2; abort_at > 0 asserts rst during that cycle.
  task automatic applyStimulus(input bit hold_start, input int abort_at,
                               input int p0, input int p1, input int p2);
    int  exp_val [M];
    bit  dead, exp_wt, exp_act, exp_we;
    int  ph, idx;
    for (int i = 0; i < M; i++) exp_val[i] = ref_out(i);
    start = 1'b1;
    for (int k = 1; k <= DONE_CYC + 1; k++) begin
      @(negedge clk);
      if (abort_at > 0 && k == abort_at + 1) rst = 1'b0;
      dead    = (abort_at > 0) && (k > abort_at);
      ph      = (k - 1) % PER;
      idx     = (k - 1) / PER;
      exp_wt  = !dead && k < DONE_CYC && ph == 0;
      exp_act = !dead && k < DONE_CYC && ph >= 1 && ph <= N;
      exp_we  = !dead && k < DONE_CYC && ph == PER - 1;
      checkOutput($sformatf("busy@%0d", k), 32'(busy), 32'(!dead && k <= DONE_CYC));
      checkOutput($sformatf("done@%0d", k), 32'(done), 32'(!dead && k == DONE_CYC));
      checkOutput($sformatf("wt_rd_en@%0d", k), 32'(wt_rd_en), 32'(exp_wt));
      checkOutput($sformatf("wt_row_addr@%0d", k), 32'(wt_row_addr), exp_wt ? idx : 0);
      checkOutput($sformatf("act_rd_en@%0d", k), 32'(act_rd_en), 32'(exp_act));
      checkOutput($sformatf("act_addr@%0d", k), 32'(act_addr), exp_act ? ph - 1 : 0);
      checkOutput($sformatf("out_we@%0d", k), 32'(out_we), 32'(exp_we));
      checkOutput($sformatf("out_addr@%0d", k), 32'(out_addr), exp_we ? idx : 0);
      checkOutput($sformatf("out_data@%0d", k), 32'(out_data), exp_we ? exp_val[idx] : 0);
      if (k == abort_at) rst = 1'b1;
      start = hold_start || k == p0 || k == p1 || k == p2;
    end
  endtask

  task automatic set_layer(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                           input logic [DW-1:0] a2, input logic [DW-1:0] a3,
                           input logic [N-1:0] r0, input logic [N-1:0] r1,
                           input logic [N-1:0] r2);
    acts[0] = a0; acts[1] = a1; acts[2] = a2; acts[3] = a3;
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    set_layer(8'd10, 8'd20, 8'd30, 8'd40, 4'b1111, 4'b0101, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("post-reset");
    end

    applyStimulus(1'b0, 0, -1, -1, -1);

    set_layer(8'd200, 8'd200, 8'd200, 8'd200, 4'b1111, 4'b0001, 4'b0011);
    applyStimulus(1'b0, 0, -1, -1, -1);

    set_layer(8'd10, 8'd20, 8'd30, 8'd40, 4'b1111, 4'b0101, 4'b0000);
    applyStimulus(1'b0, 0, 5, 14, 22);

    applyStimulus(1'b0, 10, -1, -1, -1);
    applyStimulus(1'b0, 0, -1, -1, -1);

    applyStimulus(1'b1, 0, -1, -1, -1);
    set_layer(8'd1, 8'd2, 8'd3, 8'd4, 4'b1111, 4'b0101, 4'b0000);
    applyStimulus(1'b0, 0, -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < N; j++) acts[j] = DW'($urandom);
      for (int i = 0; i < M; i++) rows[i] = N'($urandom);
      @(negedge clk);
      applyStimulus(1'b0, 0, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
